stack_arbiter: RTL and testbench
================================

# stack_arbiter

Shares a single stack-machine datapath (`main`: `in`/`op`/`apply` in, `tail`/`empty`/`valid` out) between N independent requesters. It picks one requester round-robin and drives exactly one `apply` pulse per accepted command. It waits for the datapath's `valid`, then returns `tail` and a completion pulse to the owner. Requesters can lock the datapath for atomic multi-command sequences (e.g. push, push, op).

## Interface
Parameters:
- `N`, 4 — number of requesters (2..8)
- `DW`, 8 — data width, matches datapath `in`/`tail`
- `TIMEOUT`, 8 — max WAIT cycles for `st_valid` before error

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  N  per-requester command request (level)
- `lock`  in  N  per-requester hold-ownership flag
- `req_op`  in  3N  packed op, slice i = requester i
- `req_data`  in  DW·N  packed operand
- `gnt`  out  N  one-hot, high for the ISSUE cycle of the owner's command
- `done`  out  N  one-hot, one-cycle completion pulse
- `rsp_data`  out  DW  tail captured at completion
- `rsp_err`  out  1  qualifies `done`: pop-on-empty or timeout
- `st_in`  out  DW  to datapath `in`
- `st_op`  out  3  to datapath `op`
- `st_apply`  out  1  to datapath `apply`
- `st_tail`  in  DW  from datapath `tail`
- `st_empty`  in  1  from datapath `empty`
- `st_valid`  in  1  from datapath `valid`

## Operation
- FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If `owner_locked` and `req[owner]`, select owner.
  - Otherwise, round-robin select among `req` starting at `ptr+1`.
  - Latch index, op and data, then go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (1 cycle):
  - `gnt[owner]`=1.
  - If latched op == OP_POP and `st_empty`=1: do not apply, set err, go to RESP.
  - Otherwise `st_apply`=1, `st_op`/`st_in` = latched values, go to WAIT.
- WAIT:
  - On the first cycle with `st_valid`=1, capture `st_tail` into `rsp_data` with err=0, then go to RESP.
  - After TIMEOUT cycles without `st_valid`, set err=1, `rsp_data`=0, go to RESP.
- RESP (1 cycle):
  - `done[owner]`=1 and `rsp_err` valid.
  - `ptr`←owner.
  - `owner_locked`←`lock[owner]` sampled in this cycle.
  - Go to IDLE.
- While locked:
  - Other requesters are ignored.
  - Lock releases when the owner deasserts `lock` at RESP, or is in IDLE with `req[owner]`=0.
- Requester rules:
  - Hold `req_op`/`req_data` stable from `req` rise until `done`.
  - Deassert `req` in the cycle after `done` unless another command follows.
  - A `req` drop before `gnt` is a legal withdrawal. After `gnt` the command completes regardless.
- Datapath inputs are honoured only on `st_apply`. Outside ISSUE, `st_op`/`st_in` hold their last values.
- The timeout counter is 4 bits, saturating, and cleared on ISSUE entry.

## Timing
- Reset values (async, `rst`=0):
  - state=IDLE, `ptr`=N-1 (so requester 0 wins first), `owner_locked`=0.
  - `gnt`=0, `done`=0, `rsp_data`=0, `rsp_err`=0.
  - `st_apply`=0, `st_op`=0, `st_in`=0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `req` to `gnt`.
- Latency, with `req` sampled at edge k:
  - ISSUE during cycle k+1.
  - `st_valid` is seen earliest at edge k+2.
  - `done` high in cycle k+3.
  - Minimum 3 cycles per command; back-to-back throughput is 1 command per 4 cycles.
- Pop-on-empty: `done` in cycle k+2 with no `st_apply`.
- Reset mid-operation: everything aborts immediately to reset values. No `done` is issued for the in-flight command.
- Simultaneous `req` from all N with `ptr`=N-1: grant order is 0,1,…,N-1, wrapping.

## Structure
- Package `stack_pkg`:
  - OP_PUSH=3'b101, OP_POP=3'b100, OP_ADD=3'b011, OP_W=3.
  - State enum type `arb_state_t`.
- Sub-module `rr_picker`: combinational N-bit round-robin one-hot picker (inputs req, ptr; outputs one-hot, index, any). This is instantiated once.
- Top holds the FSM, latches, timeout counter and lock register.

## Test plan
- Single requester 0 pushes 2, 4, 1 (OP_PUSH) → three `done[0]` pulses, `rsp_data`=2, 4, 1, `rsp_err`=0. Exactly three `st_apply` pulses, each 1 cycle.
- Requesters 0 and 1 hold `req` continuously with OP_PUSH → `gnt` alternates 0,1,0,1, and each `done` is 4 cycles apart.
- After reset (empty stack), requester 2 issues OP_POP → `done[2]` with `rsp_err`=1 in cycle k+2. `st_apply` is never asserted.
- Requester 0 sends PUSH 6, PUSH 0x25, OP_ADD with `lock`=1 (dropped on the last command) while requester 1 requests throughout → all three of requester 0's commands complete before the first `gnt[1]`.
- `st_valid` tied 0, TIMEOUT=8 → `done` with `rsp_err`=1, `rsp_data`=0 exactly 8 WAIT cycles after ISSUE.
- Assert `rst`=0 during WAIT → all outputs return to reset values asynchronously. After release, the next request from requester 0 is granted first.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared opcodes and arbiter state encoding for the stack-machine arbiter.
package stack_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_PUSH = 3'b101;
    localparam logic [OP_W-1:0] OP_POP  = 3'b100;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b011;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/stack_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester found searching from ptr+1 upward, wrapping.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index,
    output logic          any
);

    int              cand;
    logic [IW-1:0]   cand_idx;

    always_comb begin
        grant    = '0;
        index    = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int off = 1; off <= N; off++) begin
            cand     = (int'(ptr) + off) % N;
            cand_idx = IW'(cand);
            if (!any && req[cand_idx]) begin
                any             = 1'b1;
                grant[cand_idx] = 1'b1;
                index           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one stack datapath among N requesters, with per-owner locking
// for atomic command sequences.
module stack_arbiter
    import stack_pkg::*;
#(
    parameter int N       = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [N-1:0]       lock,
    input  logic [OP_W*N-1:0]  req_op,
    input  logic [DW*N-1:0]    req_data,
    output logic [N-1:0]       gnt,
    output logic [N-1:0]       done,
    output logic [DW-1:0]      rsp_data,
    output logic               rsp_err,
    output logic [DW-1:0]      st_in,
    output logic [OP_W-1:0]    st_op,
    output logic               st_apply,
    input  logic [DW-1:0]      st_tail,
    input  logic               st_empty,
    input  logic               st_valid,
    output logic [1:0]         dbg_state
);

    localparam int IW = $clog2(N);

    localparam logic [1:0] S_IDLE  = ARB_IDLE;
    localparam logic [1:0] S_ISSUE = ARB_ISSUE;
    localparam logic [1:0] S_WAIT  = ARB_WAIT;
    localparam logic [1:0] S_RESP  = ARB_RESP;

    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

    // Handshake: req is a level held (with stable op/data) until done; gnt marks the single
    // ISSUE cycle of the owner's command; done with rsp_data/rsp_err is a one-cycle completion.
    logic [1:0]      state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [N-1:0]    owner_oh;
    logic            owner_locked;
    logic [3:0]      tmo_cnt;

    logic [N-1:0]    pick_req;
    logic [N-1:0]    pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            pop_empty;

    // A locked owner that still requests is the only candidate the picker sees.
    assign pick_req = (owner_locked && req[owner]) ? owner_oh : req;

    rr_picker #(.N(N), .IW(IW)) u_pick (
        .req   (pick_req),
        .ptr   (ptr),
        .grant (pick_oh),
        .index (pick_idx),
        .any   (pick_any)
    );

    assign pop_empty = (st_op == OP_POP) && st_empty;
    assign st_apply  = (state == S_ISSUE) && !pop_empty;
    assign gnt       = (state == S_ISSUE) ? owner_oh : '0;
    assign done      = (state == S_RESP)  ? owner_oh : '0;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            ptr          <= IW'(N - 1);
            owner        <= '0;
            owner_oh     <= '0;
            owner_locked <= 1'b0;
            tmo_cnt      <= '0;
            st_op        <= '0;
            st_in        <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (owner_locked && !req[owner]) begin
                        owner_locked <= 1'b0;
                    end
                    if (pick_any) begin
                        owner    <= pick_idx;
                        owner_oh <= pick_oh;
                        st_op    <= req_op[int'(pick_idx)*OP_W +: OP_W];
                        st_in    <= req_data[int'(pick_idx)*DW +: DW];
                        tmo_cnt  <= '0;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (pop_empty) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        state    <= S_RESP;
                    end else begin
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (st_valid) begin
                        rsp_data <= st_tail;
                        rsp_err  <= 1'b0;
                        state    <= S_RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        state    <= S_RESP;
                    end else if (tmo_cnt != 4'hF) begin
                        tmo_cnt  <= tmo_cnt + 4'd1;
                    end
                end
                default: begin
                    ptr          <= owner;
                    owner_locked <= lock[owner];
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a small behavioural stack datapath attached.
module tb_stack_arbiter;
    import stack_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N-1:0]      lock = '0;
    logic [3*N-1:0]    req_op = '0;
    logic [DW*N-1:0]   req_data = '0;
    logic [N-1:0]      gnt;
    logic [N-1:0]      done;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;
    logic [DW-1:0]     st_in;
    logic [2:0]        st_op;
    logic              st_apply;
    logic [DW-1:0]     st_tail;
    logic              st_empty;
    logic              st_valid;
    logic [1:0]        dbg_state;

    int tests = 0;
    int failures = 0;
    int apply_cnt = 0;
    logic valid_en = 1'b1;

    stack_arbiter #(.N(N), .DW(DW), .TIMEOUT(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .lock     (lock),
        .req_op   (req_op),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .st_in    (st_in),
        .st_op    (st_op),
        .st_apply (st_apply),
        .st_tail  (st_tail),
        .st_empty (st_empty),
        .st_valid (st_valid),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Behavioural stack: tail is the top after the op, valid one cycle after apply.
    logic [DW-1:0] mem [16];
    int sp;
    assign st_empty = (sp == 0);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp       <= 0;
            st_valid <= 1'b0;
            st_tail  <= '0;
        end else begin
            st_valid <= st_apply && valid_en;
            if (st_apply) begin
                case (st_op)
                    OP_PUSH: if (sp < 16) begin
                        mem[sp] <= st_in;
                        sp      <= sp + 1;
                        st_tail <= st_in;
                    end
                    OP_POP: if (sp > 0) begin
                        sp      <= sp - 1;
                        st_tail <= (sp >= 2) ? mem[sp-2] : 8'h00;
                    end
                    OP_ADD: if (sp >= 2) begin
                        mem[sp-2] <= mem[sp-1] + mem[sp-2];
                        sp        <= sp - 1;
                        st_tail   <= mem[sp-1] + mem[sp-2];
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) if (st_apply) apply_cnt++;

    typedef struct {
        int         idx;
        logic [2:0] op;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic       exp_err;
        int         exp_lat;
        int         exp_apply;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst  = 1'b0;
        req  = '0;
        lock = '0;
        @(negedge clk);
        rst  = 1'b1;
    endtask

    task automatic set_cmd(input int idx, input logic [2:0] op, input logic [7:0] d);
        req_op[idx*3 +: 3]    = op;
        req_data[idx*DW +: DW] = d;
    endtask

    // Issue one command; lat counts negedges after the sampling edge (1 = ISSUE cycle).
    task automatic do_cmd(input int idx, input logic [2:0] op, input logic [7:0] d,
                          output logic [7:0] rd, output logic re, output int lat,
                          output logic [N-1:0] g);
        @(negedge clk);
        set_cmd(idx, op, d);
        req[idx] = 1'b1;
        lat = 0;
        g   = '0;
        rd  = '0;
        re  = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (g == '0 && gnt != '0) g = gnt;
            if (done[idx]) begin
                lat = c;
                rd  = rsp_data;
                re  = rsp_err;
                break;
            end
        end
        req[idx] = 1'b0;
    endtask

    initial begin
        logic [7:0]   rd;
        logic         re;
        int           lat;
        logic [N-1:0] g;
        int           a0;
        logic [N-1:0] g_seq [4];
        int           d_time [4];
        logic [7:0]   d_data [4];
        int           ng;
        int           nd;
        int           step;
        logic [7:0]   d1;
        logic         got1;
        int           done_seen;
        logic [2:0]   lk_op [3];
        logic [7:0]   lk_dat [3];

        vecs[0] = '{2, OP_POP,  8'h00, 8'h00, 1'b1, 2, 0};
        vecs[1] = '{0, OP_PUSH, 8'h02, 8'h02, 1'b0, 3, 1};
        vecs[2] = '{0, OP_PUSH, 8'h04, 8'h04, 1'b0, 3, 1};
        vecs[3] = '{0, OP_PUSH, 8'h01, 8'h01, 1'b0, 3, 1};
        vecs[4] = '{3, OP_ADD,  8'h00, 8'h05, 1'b0, 3, 1};
        vecs[5] = '{1, OP_POP,  8'h00, 8'h02, 1'b0, 3, 1};
        vecs[6] = '{2, OP_POP,  8'h00, 8'h00, 1'b0, 3, 1};
        vecs[7] = '{0, OP_POP,  8'h00, 8'h00, 1'b1, 2, 0};

        // Reset values
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_apply", 32'(st_apply), 0);
        check("rst_st_op", 32'(st_op), 0);
        check("rst_st_in", 32'(st_in), 0);
        check("rst_state", 32'(dbg_state), 0);
        @(negedge clk);
        rst = 1'b1;

        // Single-command vectors
        for (int i = 0; i < 8; i++) begin
            a0 = apply_cnt;
            do_cmd(vecs[i].idx, vecs[i].op, vecs[i].data, rd, re, lat, g);
            check($sformatf("vec%0d_data", i), 32'(rd), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_err", i), 32'(re), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_gnt", i), 32'(g), 32'(1 << vecs[i].idx));
            check($sformatf("vec%0d_apply", i), 32'(apply_cnt - a0), 32'(vecs[i].exp_apply));
        end

        // Two requesters holding req continuously
        reset_dut();
        @(negedge clk);
        set_cmd(0, OP_PUSH, 8'h10);
        set_cmd(1, OP_PUSH, 8'h11);
        req = 4'b0011;
        ng = 0;
        nd = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (gnt != '0 && ng < 4) begin
                g_seq[ng] = gnt;
                ng++;
            end
            if (done != '0 && nd < 4) begin
                d_time[nd] = c;
                d_data[nd] = rsp_data;
                nd++;
                if (nd == 4) begin
                    req = '0;
                    break;
                end
            end
        end
        req = '0;
        check("rr_done_count", 32'(nd), 4);
        if (nd == 4) begin
            check("rr_first_done", 32'(d_time[0]), 3);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rr_gnt%0d", i), 32'(g_seq[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
                check($sformatf("rr_data%0d", i), 32'(d_data[i]), (i % 2 == 0) ? 32'h10 : 32'h11);
            end
            for (int i = 0; i < 3; i++)
                check($sformatf("rr_gap%0d", i), 32'(d_time[i+1] - d_time[i]), 4);
        end

        // Locked atomic sequence from requester 0 against a competing requester 1
        reset_dut();
        lk_op[0] = OP_PUSH; lk_dat[0] = 8'h06;
        lk_op[1] = OP_PUSH; lk_dat[1] = 8'h25;
        lk_op[2] = OP_ADD;  lk_dat[2] = 8'h00;
        @(negedge clk);
        set_cmd(0, lk_op[0], lk_dat[0]);
        set_cmd(1, OP_PUSH, 8'h77);
        lock[0] = 1'b1;
        req = 4'b0011;
        ng = 0;
        step = 0;
        got1 = 1'b0;
        d1 = '0;
        for (int i = 0; i < 3; i++) d_data[i] = '0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (gnt != '0 && ng < 4) begin
                g_seq[ng] = gnt;
                ng++;
                if (gnt[0] && step == 2) lock[0] = 1'b0;
            end
            if (done[0] && step < 3) begin
                d_data[step] = rsp_data;
                step++;
                if (step < 3) set_cmd(0, lk_op[step], lk_dat[step]);
                else req[0] = 1'b0;
            end
            if (done[1]) begin
                d1 = rsp_data;
                got1 = 1'b1;
                req[1] = 1'b0;
                break;
            end
        end
        req = '0;
        lock = '0;
        check("lock_gnt_count", 32'(ng), 4);
        if (ng == 4) begin
            check("lock_gnt0", 32'(g_seq[0]), 32'h1);
            check("lock_gnt1", 32'(g_seq[1]), 32'h1);
            check("lock_gnt2", 32'(g_seq[2]), 32'h1);
            check("lock_gnt3", 32'(g_seq[3]), 32'h2);
        end
        check("lock_data0", 32'(d_data[0]), 32'h06);
        check("lock_data1", 32'(d_data[1]), 32'h25);
        check("lock_data2", 32'(d_data[2]), 32'h2B);
        check("lock_r1_done", 32'(got1), 1);
        check("lock_r1_data", 32'(d1), 32'h77);

        // Timeout: datapath never answers
        reset_dut();
        valid_en = 1'b0;
        do_cmd(0, OP_PUSH, 8'h09, rd, re, lat, g);
        valid_en = 1'b1;
        check("tmo_lat", 32'(lat), 10);
        check("tmo_err", 32'(re), 1);
        check("tmo_data", 32'(rd), 0);
        check("tmo_gnt", 32'(g), 32'h1);

        // Reset in the middle of WAIT
        reset_dut();
        do_cmd(3, OP_PUSH, 8'h5A, rd, re, lat, g);
        check("mid_pre_data", 32'(rd), 32'h5A);
        valid_en = 1'b0;
        @(negedge clk);
        set_cmd(2, OP_PUSH, 8'h33);
        req[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_in_wait", 32'(dbg_state), 2);
        rst = 1'b0;
        #1;
        check("mid_gnt", 32'(gnt), 0);
        check("mid_done", 32'(done), 0);
        check("mid_rsp_data", 32'(rsp_data), 0);
        check("mid_rsp_err", 32'(rsp_err), 0);
        check("mid_apply", 32'(st_apply), 0);
        check("mid_st_op", 32'(st_op), 0);
        check("mid_st_in", 32'(st_in), 0);
        check("mid_state", 32'(dbg_state), 0);
        req = '0;
        done_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done != '0) done_seen++;
        end
        rst = 1'b1;
        valid_en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done != '0) done_seen++;
        end
        check("mid_no_done", 32'(done_seen), 0);
        set_cmd(0, OP_PUSH, 8'h44);
        set_cmd(2, OP_PUSH, 8'h55);
        req = 4'b0101;
        g = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                g = gnt;
                break;
            end
        end
        req = '0;
        check("post_rst_first_gnt", 32'(g), 32'h1);
        rd = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done[0]) begin
                rd = rsp_data;
                break;
            end
        end
        check("post_rst_data", 32'(rd), 32'h44);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
